pwm_shift_serializer: RTL

- Parametrised multi-channel PWM generator that drives a daisy-chained external serial-in/parallel-out shift register (595-style) through three pins: sclk, sdata and latch.
- For each PWM tick it computes NUM_CH compare bits, shifts them out, then pulses latch. The PWM counter advances once per completed frame.
- Per-channel duty values are runtime-writable through a shadow/active double buffer. New values take effect only at a period wrap, so no glitched PWM cycles occur.
- Sits between the control register interface and the board-level shift-register chain.

---
 rtl/pwm_ser_pkg.sv | 20 ++
 rtl/pwm_duty_bank.sv | 53 +++++
 rtl/pwm_shift_serializer.sv | 118 +++++++++++
 3 files changed

// File: rtl/pwm_ser_pkg.sv
// Shared types and defaults for the PWM shift-register serializer.
package pwm_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } ser_state_t;

  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned PERIOD_DEF = 100;

  // Width of a channel index; a single-channel chain still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_duty_bank.sv
// Shadow/active duty registers with wrap-time transfer and per-channel
// compare against the PWM counter.
module pwm_duty_bank
  import pwm_ser_pkg::*;
#(
  parameter int unsigned      NUM_CH    = NUM_CH_DEF,
  parameter int unsigned      CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DUTY_INIT = '0,
  parameter int unsigned      IDX_W     = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0]  wr_duty,
  input  logic              wrap,
  input  logic [CNT_W-1:0]  cnt,
  output logic [NUM_CH-1:0] cmp_bits
);

  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] active [NUM_CH];
  logic             wr_hit;

  always_comb wr_hit = wr_en && (32'(wr_ch) < NUM_CH);

  // Non-blocking transfer reads the pre-write shadow when a write shares the wrap edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= DUTY_INIT;
        active[i] <= DUTY_INIT;
      end
    end else begin
      if (wrap) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (wr_hit) begin
        shadow[wr_ch] <= wr_duty;
      end
    end
  end

  always_comb begin
    cmp_bits = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cmp_bits[i] = (cnt < active[i]);
    end
  end

endmodule

// File: rtl/pwm_shift_serializer.sv
// Multi-channel PWM generator driving a daisy-chained 595-style shift
// register: shift NUM_CH compare bits MSB-channel first, then pulse latch.
module pwm_shift_serializer
  import pwm_ser_pkg::*;
#(
  parameter int unsigned      NUM_CH    = NUM_CH_DEF,
  parameter int unsigned      CNT_W     = CNT_W_DEF,
  parameter int unsigned      PERIOD    = PERIOD_DEF,
  parameter logic [CNT_W-1:0] DUTY_INIT = '0,
  localparam int unsigned     IDX_W     = idx_width(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             frame_done,
  output logic             period_wrap,
  output logic [CNT_W-1:0] pwm_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] K_FIRST  = IDX_W'(NUM_CH - 1);

  ser_state_t        state;
  logic [IDX_W-1:0]  k;
  logic [NUM_CH-1:0] shreg;
  logic [NUM_CH-1:0] shreg_next;
  logic [NUM_CH-1:0] cmp_bits;
  logic [CNT_W-1:0]  cnt_inc;
  logic              at_wrap;
  logic              frame_end;
  logic              wrap_xfer;

  always_comb begin
    at_wrap    = (pwm_cnt == CNT_LAST);
    cnt_inc    = at_wrap ? '0 : pwm_cnt + CNT_W'(1);
    frame_end  = (state == SHIFT_HI) && (k == '0);
    wrap_xfer  = frame_end && at_wrap;
    shreg_next = shreg << 1;
  end

  pwm_duty_bank #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DUTY_INIT (DUTY_INIT),
    .IDX_W     (IDX_W)
  ) u_duty_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_duty  (wr_duty),
    .wrap     (wrap_xfer),
    .cnt      (pwm_cnt),
    .cmp_bits (cmp_bits)
  );

  // Counter and active duties update on the edge into LATCH, so the snapshot
  // taken when leaving LATCH already reflects the next frame's values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      k           <= '0;
      shreg       <= '0;
      sclk        <= 1'b0;
      sdata       <= 1'b0;
      latch       <= 1'b0;
      frame_done  <= 1'b0;
      period_wrap <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      latch       <= 1'b0;
      frame_done  <= 1'b0;
      period_wrap <= 1'b0;
      unique case (state)
        IDLE, LATCH: begin
          sclk <= 1'b0;
          if (enable) begin
            state <= SHIFT_LO;
            k     <= K_FIRST;
            shreg <= cmp_bits;
            sdata <= cmp_bits[NUM_CH-1];
          end else begin
            state <= IDLE;
            sdata <= 1'b0;
          end
        end
        SHIFT_LO: begin
          state <= SHIFT_HI;
          sclk  <= 1'b1;
        end
        SHIFT_HI: begin
          sclk <= 1'b0;
          if (k == '0) begin
            state       <= LATCH;
            sdata       <= 1'b0;
            latch       <= 1'b1;
            frame_done  <= 1'b1;
            period_wrap <= at_wrap;
            pwm_cnt     <= cnt_inc;
          end else begin
            state <= SHIFT_LO;
            k     <= k - IDX_W'(1);
            shreg <= shreg_next;
            sdata <= shreg_next[NUM_CH-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
